// File: rtl/regfile_arb_2port_if.sv
// -----------------------------------------------------------------------------
// regfile_arb_2port_if
//   Bundles the two requesters' request and response channels of the
//   regfile_arb_2port arbiter.
//
//   Parameters
//      p_nbits : data width of one regfile word
//      p_nregs : number of regfile words (address width = $clog2(p_nregs))
//
//   Signals (per requester N = 0/1)
//      reqN_val/reqN_rdy      request handshake (rdy = grant this cycle)
//      reqN_type              0 = read, 1 = write
//      reqN_addr/reqN_data    word address / write data
//      respN_val/respN_rdy    response handshake (val = response buffer full)
//      respN_type/respN_data  type of completed request / read data (0 for writes)
//
//   Modports
//      master : client engine side (drives requests, consumes responses)
//      slave  : arbiter side
// -----------------------------------------------------------------------------
interface regfile_arb_2port_if #(
   parameter int p_nbits = 4,
   parameter int p_nregs = 4
);
   logic                       req0_val;
   logic                       req0_rdy;
   logic                       req0_type;
   logic [$clog2(p_nregs)-1:0] req0_addr;
   logic [p_nbits-1:0]         req0_data;
   logic                       resp0_val;
   logic                       resp0_rdy;
   logic                       resp0_type;
   logic [p_nbits-1:0]         resp0_data;

   logic                       req1_val;
   logic                       req1_rdy;
   logic                       req1_type;
   logic [$clog2(p_nregs)-1:0] req1_addr;
   logic [p_nbits-1:0]         req1_data;
   logic                       resp1_val;
   logic                       resp1_rdy;
   logic                       resp1_type;
   logic [p_nbits-1:0]         resp1_data;

   modport master (
      output req0_val, req0_type, req0_addr, req0_data, resp0_rdy,
      input  req0_rdy, resp0_val, resp0_type, resp0_data,
      output req1_val, req1_type, req1_addr, req1_data, resp1_rdy,
      input  req1_rdy, resp1_val, resp1_type, resp1_data
   );

   modport slave (
      input  req0_val, req0_type, req0_addr, req0_data, resp0_rdy,
      output req0_rdy, resp0_val, resp0_type, resp0_data,
      input  req1_val, req1_type, req1_addr, req1_data, resp1_rdy,
      output req1_rdy, resp1_val, resp1_type, resp1_data
   );
endinterface

// File: rtl/regfile_arb_2port.sv
// -----------------------------------------------------------------------------
// regfile_arb_2port
//   Round-robin arbiter/sequencer sharing one 1R/1W register file with a
//   combinational read port between two requesters. At most one request is
//   granted per cycle; the granted request drives the regfile ports directly
//   and its response is captured into that requester's one-entry buffer at
//   the same clock edge (1-cycle latency).
//
//   Optional feature macro: REGFILE_ARB_FIXED_PRIO_EN
//      defined   : requester 0 always wins a tie (requester 1 may starve)
//      undefined : round-robin tie break (default)
//
//   Ports
//      clk       clock, all state on posedge
//      rst_n     asynchronous active-low reset
//      bus       regfile_arb_2port_if.slave, both requesters' channels
//      rf_wen    regfile write enable (forced 0 while rst_n=0)
//      rf_waddr  regfile write address
//      rf_wdata  regfile write data
//      rf_raddr  regfile read address (0 when nothing is granted)
//      rf_rdata  regfile combinational read data
// -----------------------------------------------------------------------------
module regfile_arb_2port #(
   parameter int p_nbits = 4,
   parameter int p_nregs = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   regfile_arb_2port_if.slave         bus,
   output logic                       rf_wen,
   output logic [$clog2(p_nregs)-1:0] rf_waddr,
   output logic [p_nbits-1:0]         rf_wdata,
   output logic [$clog2(p_nregs)-1:0] rf_raddr,
   input  logic [p_nbits-1:0]         rf_rdata
);
   localparam int c_aw = $clog2(p_nregs);

   // Requester channels flattened into index-able form
   logic [1:0]         req_val;
   logic [1:0]         req_type;
   logic [1:0]         resp_rdy;
   logic [c_aw-1:0]    req_addr [2];
   logic [p_nbits-1:0] req_data [2];

   logic [1:0]         resp_val;
   logic [1:0]         resp_type;
   logic [p_nbits-1:0] resp_data [2];

   logic [1:0]         elig;
   logic [1:0]         grant;
   logic               any_grant;
   logic               sel;
   logic               prio;

   assign req_val     = {bus.req1_val,  bus.req0_val};
   assign req_type    = {bus.req1_type, bus.req0_type};
   assign resp_rdy    = {bus.resp1_rdy, bus.resp0_rdy};
   assign req_addr[0] = bus.req0_addr;
   assign req_addr[1] = bus.req1_addr;
   assign req_data[0] = bus.req0_data;
   assign req_data[1] = bus.req1_data;

   // A full buffer blocks a new grant even if it drains this same cycle, so
   // there is no combinational path from resp_rdy to req_rdy.
   assign elig = req_val & ~resp_val;

   // Grants are gated by rst_n so nothing (in particular no write) is
   // accepted in a cycle where reset is asserted asynchronously.
   assign grant[0] = rst_n & elig[0] & (~elig[1] | ~prio);
   assign grant[1] = rst_n & elig[1] & (~elig[0] |  prio);

   assign any_grant = |grant;
   assign sel       = grant[1];   // index of the granted requester

   assign rf_raddr = any_grant ? req_addr[sel] : '0;
   assign rf_waddr = req_addr[sel];
   assign rf_wdata = req_data[sel];
   assign rf_wen   = any_grant & req_type[sel];

   assign bus.req0_rdy   = grant[0];
   assign bus.req1_rdy   = grant[1];
   assign bus.resp0_val  = resp_val[0];
   assign bus.resp1_val  = resp_val[1];
   assign bus.resp0_type = resp_type[0];
   assign bus.resp1_type = resp_type[1];
   assign bus.resp0_data = resp_data[0];
   assign bus.resp1_data = resp_data[1];

   // -------------------------------------------------------------------------
   // Tie-break priority
   // -------------------------------------------------------------------------
`ifdef REGFILE_ARB_FIXED_PRIO_EN
   assign prio = 1'b0;
`else
   logic prio_q;
   logic prio_d;

   // The requester just served loses the next tie.
   always_comb begin
      prio_d = prio_q;
      if (grant[0]) begin
         prio_d = 1'b1;
      end else if (grant[1]) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign prio = prio_q;
`endif

   // -------------------------------------------------------------------------
   // Per-requester one-entry response buffers
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         logic               val_q;
         logic               val_d;
         logic               type_q;
         logic               type_d;
         logic [p_nbits-1:0] data_q;
         logic [p_nbits-1:0] data_d;

         // Grant and drain are mutually exclusive: a grant needs an empty
         // buffer, a drain needs a full one. Draining keeps type/data.
         always_comb begin
            val_d  = val_q;
            type_d = type_q;
            data_d = data_q;
            if (grant[gi]) begin
               val_d  = 1'b1;
               type_d = req_type[gi];
               // rf_rdata is the pre-write value: only one op per cycle.
               data_d = req_type[gi] ? '0 : rf_rdata;
            end else if (val_q && resp_rdy[gi]) begin
               val_d = 1'b0;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               val_q  <= 1'b0;
               type_q <= 1'b0;
               data_q <= '0;
            end else begin
               val_q  <= val_d;
               type_q <= type_d;
               data_q <= data_d;
            end
         end

         assign resp_val[gi]  = val_q;
         assign resp_type[gi] = type_q;
         assign resp_data[gi] = data_q;
      end
   endgenerate

endmodule
